// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - StallBus encodings, sequencer states and canned code sets
package pipe_stall_ctrl_pkg;

  localparam int STALL_W = 2;

  typedef enum logic [STALL_W-1:0] {
    STALL_PASS = 2'b00,
    STALL_HOLD = 2'b01,
    STALL_BUBB = 2'b10
  } stall_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    stall_e pc;
    stall_e if_id;
    stall_e id_ex;
    stall_e ex_mem;
    stall_e mem_wb;
  } stall_bus_t;

  localparam stall_bus_t BUS_PASS  = '{STALL_PASS, STALL_PASS, STALL_PASS, STALL_PASS, STALL_PASS};
  localparam stall_bus_t BUS_HOLD  = '{STALL_HOLD, STALL_HOLD, STALL_HOLD, STALL_HOLD, STALL_HOLD};
  localparam stall_bus_t BUS_BUBB  = '{STALL_BUBB, STALL_BUBB, STALL_BUBB, STALL_BUBB, STALL_BUBB};
  localparam stall_bus_t BUS_MEMW  = '{STALL_HOLD, STALL_HOLD, STALL_HOLD, STALL_HOLD, STALL_BUBB};
  localparam stall_bus_t BUS_FLUSH = '{STALL_PASS, STALL_BUBB, STALL_BUBB, STALL_PASS, STALL_PASS};
  localparam stall_bus_t BUS_LDUSE = '{STALL_HOLD, STALL_HOLD, STALL_BUBB, STALL_PASS, STALL_PASS};
  localparam stall_bus_t BUS_IFW   = '{STALL_HOLD, STALL_BUBB, STALL_PASS, STALL_PASS, STALL_PASS};
  // While draining, IF/ID is bubbled even when MEM holds the back end: its content is wrong-path.
  localparam stall_bus_t BUS_DRAIN_MEMW = '{STALL_HOLD, STALL_BUBB, STALL_HOLD, STALL_HOLD, STALL_BUBB};

endpackage

// File: rtl/stall_perf_cnt.sv
// rtl/stall_perf_cnt.sv - stall/flush perf counters and sticky MEM-wait watchdog
module stall_perf_cnt #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             mem_busy_i,
  output logic [CNT_W-1:0] perf_stall_o,
  output logic [CNT_W-1:0] perf_flush_o,
  output logic             mem_timeout_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    if (en_i) begin
      if (stall_i) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_i) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      if (!mem_busy_i)             wait_cnt_d = '0;
      else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      // Flag sets on the same edge the wait count reaches the limit.
      if (wait_cnt_d == WAIT_MAX) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign perf_stall_o  = stall_cnt_q;
  assign perf_flush_o  = flush_cnt_q;
  assign mem_timeout_o = timeout_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - 5-stage pipeline hazard/stall sequencer with wrong-path fetch drain
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy_in,
  input  logic               if_busy_i,
  input  logic               mem_busy_i,
  input  logic               load_use_i,
  input  logic               ex_jump_i,
  output logic [STALL_W-1:0] stall_pc_o,
  output logic [STALL_W-1:0] stall_if_id_o,
  output logic [STALL_W-1:0] stall_id_ex_o,
  output logic [STALL_W-1:0] stall_ex_mem_o,
  output logic [STALL_W-1:0] stall_mem_wb_o,
  output logic               if_kill_o,
  output logic [CNT_W-1:0]   perf_stall_o,
  output logic [CNT_W-1:0]   perf_flush_o,
  output logic               mem_timeout_o
);

  state_e     state_q, state_d;
  stall_bus_t bus;
  logic       kill;
  logic       flush_inc;
  logic       stall_inc;

  always_comb begin
    state_d   = state_q;
    bus       = BUS_PASS;
    kill      = 1'b0;
    flush_inc = 1'b0;
    if (!rdy_in) begin
      bus = BUS_HOLD;
    end else if (state_q == ST_RUN) begin
      if (mem_busy_i) begin
        bus = BUS_MEMW;
      end else if (ex_jump_i) begin
        bus       = BUS_FLUSH;
        flush_inc = 1'b1;
        if (if_busy_i) begin
          kill    = 1'b1;
          state_d = ST_DRAIN;
        end
      end else if (load_use_i) begin
        bus = BUS_LDUSE;
      end else if (if_busy_i) begin
        bus = BUS_IFW;
      end
    end else begin
      kill = 1'b1;
      if (!if_busy_i) state_d = ST_RUN;
      if (mem_busy_i) begin
        bus = BUS_DRAIN_MEMW;
      end else if (ex_jump_i) begin
        bus       = BUS_FLUSH;
        flush_inc = 1'b1;
      end else begin
        bus = BUS_IFW;
      end
    end
    stall_inc = rdy_in && (bus.pc != STALL_PASS);
    if (rst) begin
      bus  = BUS_BUBB;
      kill = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else if (rdy_in) state_q <= state_d;
  end

  assign stall_pc_o     = bus.pc;
  assign stall_if_id_o  = bus.if_id;
  assign stall_id_ex_o  = bus.id_ex;
  assign stall_ex_mem_o = bus.ex_mem;
  assign stall_mem_wb_o = bus.mem_wb;
  assign if_kill_o      = kill;

  stall_perf_cnt #(
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_perf (
    .clk           (clk),
    .rst           (rst),
    .en_i          (rdy_in),
    .stall_i       (stall_inc),
    .flush_i       (flush_inc),
    .mem_busy_i    (mem_busy_i),
    .perf_stall_o  (perf_stall_o),
    .perf_flush_o  (perf_flush_o),
    .mem_timeout_o (mem_timeout_o)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

  localparam logic [1:0] P = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] B = 2'b10;
  localparam logic [9:0] C_PASS  = {P, P, P, P, P};
  localparam logic [9:0] C_HOLD  = {H, H, H, H, H};
  localparam logic [9:0] C_BUBB  = {B, B, B, B, B};
  localparam logic [9:0] C_MEMW  = {H, H, H, H, B};
  localparam logic [9:0] C_FLUSH = {P, B, B, P, P};
  localparam logic [9:0] C_LDUSE = {H, H, B, P, P};
  localparam logic [9:0] C_DRAIN = {H, B, P, P, P};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy_in = 1'b1;
  logic        if_busy_i = 1'b0;
  logic        mem_busy_i = 1'b0;
  logic        load_use_i = 1'b0;
  logic        ex_jump_i = 1'b0;
  logic [1:0]  stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o, stall_mem_wb_o;
  logic        if_kill_o;
  logic [31:0] perf_stall_o, perf_flush_o;
  logic        mem_timeout_o;
  logic [9:0]  codes;

  int n_run  = 0;
  int n_fail = 0;

  assign codes = {stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o, stall_mem_wb_o};

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.CNT_W(32), .MEM_TIMEOUT(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy_in         (rdy_in),
    .if_busy_i      (if_busy_i),
    .mem_busy_i     (mem_busy_i),
    .load_use_i     (load_use_i),
    .ex_jump_i      (ex_jump_i),
    .stall_pc_o     (stall_pc_o),
    .stall_if_id_o  (stall_if_id_o),
    .stall_id_ex_o  (stall_id_ex_o),
    .stall_ex_mem_o (stall_ex_mem_o),
    .stall_mem_wb_o (stall_mem_wb_o),
    .if_kill_o      (if_kill_o),
    .perf_stall_o   (perf_stall_o),
    .perf_flush_o   (perf_flush_o),
    .mem_timeout_o  (mem_timeout_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rdy, input logic ifb, input logic memb,
                        input logic lu, input logic jmp);
    rdy_in = rdy; if_busy_i = ifb; mem_busy_i = memb; load_use_i = lu; ex_jump_i = jmp;
    #1;
  endtask

  task automatic do_reset;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    tick();
    n_run++;
    if (codes !== C_BUBB) begin n_fail++; $display("FAIL rst_codes: got %b want %b", codes, C_BUBB); end
    n_run++;
    if ({if_kill_o, mem_timeout_o, perf_stall_o, perf_flush_o} !== 66'd0) begin
      n_fail++; $display("FAIL rst_state: kill %b tmo %b stall %0d flush %0d want all 0",
                         if_kill_o, mem_timeout_o, perf_stall_o, perf_flush_o);
    end
    rst = 1'b0;
    #1;
    n_run++;
    if (codes !== C_PASS) begin n_fail++; $display("FAIL rst_release: got %b want %b", codes, C_PASS); end
  endtask

  task automatic test_load_use;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      n_run++;
      if (codes !== C_LDUSE || if_kill_o !== 1'b0) begin
        n_fail++; $display("FAIL lu_codes c%0d: got %b kill %b want %b kill 0", c, codes, if_kill_o, C_LDUSE);
      end
      tick();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_run++;
    if (codes !== C_PASS) begin n_fail++; $display("FAIL lu_after: got %b want %b", codes, C_PASS); end
    n_run++;
    if (perf_stall_o !== 32'd2 || perf_flush_o !== 32'd0) begin
      n_fail++; $display("FAIL lu_perf: stall %0d flush %0d want 2 0", perf_stall_o, perf_flush_o);
    end
  endtask

  task automatic test_flush_drain;
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    n_run++;
    if (codes !== C_FLUSH || if_kill_o !== 1'b1) begin
      n_fail++; $display("FAIL fl_c0: got %b kill %b want %b kill 1", codes, if_kill_o, C_FLUSH);
    end
    tick();
    for (int c = 1; c <= 3; c++) begin
      set_in(1'b1, (c < 3), 1'b0, 1'b0, 1'b0);
      n_run++;
      if (codes !== C_DRAIN || if_kill_o !== 1'b1) begin
        n_fail++; $display("FAIL fl_drain c%0d: got %b kill %b want %b kill 1", c, codes, if_kill_o, C_DRAIN);
      end
      tick();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_run++;
    if (codes !== C_PASS || if_kill_o !== 1'b0) begin
      n_fail++; $display("FAIL fl_c4: got %b kill %b want %b kill 0", codes, if_kill_o, C_PASS);
    end
    n_run++;
    if (perf_flush_o !== 32'd1 || perf_stall_o !== 32'd3) begin
      n_fail++; $display("FAIL fl_perf: flush %0d stall %0d want 1 3", perf_flush_o, perf_stall_o);
    end
  endtask

  task automatic test_mem_jump;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      n_run++;
      if (codes !== C_MEMW || if_kill_o !== 1'b0) begin
        n_fail++; $display("FAIL mj_wait c%0d: got %b kill %b want %b kill 0", c, codes, if_kill_o, C_MEMW);
      end
      tick();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_run++;
    if (codes !== C_FLUSH || if_kill_o !== 1'b0) begin
      n_fail++; $display("FAIL mj_flush: got %b kill %b want %b kill 0", codes, if_kill_o, C_FLUSH);
    end
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_run++;
    if (perf_flush_o !== 32'd1 || perf_stall_o !== 32'd4 || mem_timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL mj_perf: flush %0d stall %0d tmo %b want 1 4 0",
                         perf_flush_o, perf_stall_o, mem_timeout_o);
    end
  endtask

  task automatic test_drain_jump;
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    n_run++;
    if (codes !== C_FLUSH || if_kill_o !== 1'b1) begin
      n_fail++; $display("FAIL dj_flush: got %b kill %b want %b kill 1", codes, if_kill_o, C_FLUSH);
    end
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_run++;
    if (codes !== C_DRAIN || if_kill_o !== 1'b1) begin
      n_fail++; $display("FAIL dj_stay: got %b kill %b want %b kill 1", codes, if_kill_o, C_DRAIN);
    end
    tick();
    n_run++;
    if (codes !== C_PASS || perf_flush_o !== 32'd2) begin
      n_fail++; $display("FAIL dj_exit: got %b flush %0d want %b 2", codes, perf_flush_o, C_PASS);
    end
  endtask

  task automatic test_watchdog;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_run++;
    if (mem_timeout_o !== 1'b0) begin n_fail++; $display("FAIL wd_gap: got %b want 0", mem_timeout_o); end
    for (int c = 1; c <= 8; c++) begin
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      n_run++;
      if (mem_timeout_o !== (c == 8)) begin
        n_fail++; $display("FAIL wd_edge%0d: got %b want %b", c, mem_timeout_o, (c == 8));
      end
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    n_run++;
    if (mem_timeout_o !== 1'b1 || perf_stall_o !== 32'd15) begin
      n_fail++; $display("FAIL wd_sticky: tmo %b stall %0d want 1 15", mem_timeout_o, perf_stall_o);
    end
  endtask

  task automatic test_rdy_freeze;
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      n_run++;
      if (codes !== C_HOLD || if_kill_o !== 1'b0) begin
        n_fail++; $display("FAIL rf_hold c%0d: got %b kill %b want %b kill 0", c, codes, if_kill_o, C_HOLD);
      end
      tick();
    end
    n_run++;
    if (perf_stall_o !== 32'd0 || perf_flush_o !== 32'd1) begin
      n_fail++; $display("FAIL rf_perf: stall %0d flush %0d want 0 1", perf_stall_o, perf_flush_o);
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_run++;
    if (codes !== C_DRAIN || if_kill_o !== 1'b1) begin
      n_fail++; $display("FAIL rf_resume: got %b kill %b want %b kill 1", codes, if_kill_o, C_DRAIN);
    end
    tick();
    n_run++;
    if (codes !== C_PASS || if_kill_o !== 1'b0) begin
      n_fail++; $display("FAIL rf_run: got %b kill %b want %b kill 0", codes, if_kill_o, C_PASS);
    end
  endtask

  task automatic test_reset_async;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_run++;
    if (if_kill_o !== 1'b1 || mem_timeout_o !== 1'b1) begin
      n_fail++; $display("FAIL ra_pre: kill %b tmo %b want 1 1", if_kill_o, mem_timeout_o);
    end
    #2;
    rst = 1'b1;
    #1;
    n_run++;
    if (codes !== C_BUBB || if_kill_o !== 1'b0) begin
      n_fail++; $display("FAIL ra_codes: got %b kill %b want %b kill 0", codes, if_kill_o, C_BUBB);
    end
    n_run++;
    if (perf_stall_o !== 32'd0 || perf_flush_o !== 32'd0 || mem_timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL ra_cnt: stall %0d flush %0d tmo %b want 0 0 0",
                         perf_stall_o, perf_flush_o, mem_timeout_o);
    end
    tick();
    rst = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_run++;
    if (codes !== C_PASS || if_kill_o !== 1'b0) begin
      n_fail++; $display("FAIL ra_run: got %b kill %b want %b kill 0", codes, if_kill_o, C_PASS);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_flush_drain();
    test_mem_jump();
    test_drain_jump();
    test_watchdog();
    test_rdy_freeze();
    test_reset_async();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
